// File: rtl/peri_pkg.sv
// Shared types for the peripheral write queue: drain FSM states, default
// bus widths and the packed queue entry layout.
package peri_pkg;

    localparam int PERI_AW = 16;
    localparam int PERI_DW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } peri_state_t;

    typedef struct packed {
        logic [PERI_AW-1:0] addr;
        logic [PERI_DW-1:0] data;
    } peri_entry_t;

endpackage

// File: rtl/peri_fifo.sv
// Synchronous FIFO with push, pop and an in-place tail overwrite port.
// Pointers wrap naturally; the occupancy count is kept separately.
module peri_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int KEY_W = 16
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       ovr,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               head,
    output logic [KEY_W-1:0]           tail_key,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] tail_ptr;
    logic [W-1:0]  tail_word;

    assign tail_ptr  = wptr - 1'b1;
    assign tail_word = mem[tail_ptr];
    assign head      = mem[rptr];
    // Only the upper KEY_W bits (the address) are needed for the tail compare.
    assign tail_key  = tail_word[W-1 -: KEY_W];

    always_ff @(posedge clk) begin
        if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!clr && push) begin
            mem[wptr] <= wdata;
        end else if (!clr && ovr) begin
            mem[tail_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/peri_write_queue.sv
// Buffered peripheral write path: a DEPTH-entry store queue drained by an
// FSM that strobes peri_web, waits for peri_ack and inserts an idle gap.
module peri_write_queue
    import peri_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int AW         = PERI_AW,
    parameter int DW         = PERI_DW,
    parameter int GAP_CYCLES = 1,
    parameter int COALESCE   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       boot_up,
    input  logic                       st_valid,
    input  logic [AW-1:0]              st_addr,
    input  logic [DW-1:0]              st_data,
    output logic                       st_ready,
    output logic                       peri_web,
    output logic [AW-1:0]              peri_addr,
    output logic [DW-1:0]              peri_datao,
    input  logic                       peri_ack,
    output logic [$clog2(DEPTH+1)-1:0] wq_count,
    output logic                       wq_idle,
    output logic [1:0]                 dbg_state
);

    localparam int CW       = $clog2(DEPTH+1);
    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam bit ZERO_GAP = (GAP_CYCLES == 0);
    localparam bit DO_COAL  = (COALESCE != 0);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    peri_state_t   state;
    logic [GW-1:0] gap_cnt;
    logic          clr;
    logic [CW-1:0] count;
    entry_t        head;
    logic [AW-1:0] tail_addr;
    logic          st_accept;
    logic          pop;
    logic          tail_popped;
    logic          coal;
    logic          push;

    assign clr = !rst_n || boot_up;

    // Handshake: a store transfers on an edge where st_valid && st_ready.
    // st_ready depends on count only, so it never combinationally follows
    // st_valid; a full queue refuses even a store that would coalesce.
    assign st_ready  = (count != CW'(DEPTH));
    assign st_accept = st_valid && st_ready && !clr;

    assign pop = !clr && (count != '0) &&
                 ((state == IDLE) || (ZERO_GAP && state == STROBE && peri_ack));

    // The in-flight write lives in the output registers, so only queued
    // entries are coalescing candidates, and never one leaving this edge.
    assign tail_popped = pop && (count == CW'(1));
    assign coal = DO_COAL && st_accept && (count != '0) &&
                  (tail_addr == st_addr) && !tail_popped;
    assign push = st_accept && !coal;

    peri_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW),
        .KEY_W (AW)
    ) u_fifo (
        .clk      (clk),
        .clr      (clr),
        .push     (push),
        .pop      (pop),
        .ovr      (coal),
        .wdata    ({st_addr, st_data}),
        .head     (head),
        .tail_key (tail_addr),
        .count    (count)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            peri_web   <= 1'b1;
            peri_addr  <= '0;
            peri_datao <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        peri_addr  <= head.addr;
                        peri_datao <= head.data;
                        peri_web   <= 1'b0;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    if (peri_ack) begin
                        if (!ZERO_GAP) begin
                            peri_web <= 1'b1;
                            gap_cnt  <= GAP_LOAD;
                            state    <= GAP;
                        end else if (pop) begin
                            peri_addr  <= head.addr;
                            peri_datao <= head.data;
                        end else begin
                            peri_web <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) state <= IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: begin
                    peri_web <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign wq_count  = count;
    assign wq_idle   = (count == '0) && (state == IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_peri_write_queue.sv
// Directed bench for peri_write_queue: a GAP_CYCLES=1 coalescing instance and
// a GAP_CYCLES=0 instance share one stimulus stream.
module tb_peri_write_queue;
    import peri_pkg::*;

    localparam int EW = $bits(peri_entry_t);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        boot_up = 1'b0;
    logic        st_valid = 1'b0;
    logic [15:0] st_addr = '0;
    logic [15:0] st_data = '0;
    logic        peri_ack = 1'b0;

    logic        st_ready, peri_web, wq_idle;
    logic [15:0] peri_addr, peri_datao;
    logic [2:0]  wq_count;
    logic [1:0]  dbg_state;

    logic        st_ready0, peri_web0, wq_idle0;
    logic [15:0] peri_addr0, peri_datao0;
    logic [2:0]  wq_count0;
    logic [1:0]  dbg_state0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    peri_write_queue #(.DEPTH(4), .AW(16), .DW(16), .GAP_CYCLES(1), .COALESCE(1)) dut (
        .clk(clk), .rst_n(rst_n), .boot_up(boot_up), .st_valid(st_valid),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .peri_web(peri_web), .peri_addr(peri_addr), .peri_datao(peri_datao),
        .peri_ack(peri_ack), .wq_count(wq_count), .wq_idle(wq_idle),
        .dbg_state(dbg_state)
    );

    peri_write_queue #(.DEPTH(4), .AW(16), .DW(16), .GAP_CYCLES(0), .COALESCE(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .boot_up(boot_up), .st_valid(st_valid),
        .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready0),
        .peri_web(peri_web0), .peri_addr(peri_addr0), .peri_datao(peri_datao0),
        .peri_ack(peri_ack), .wq_count(wq_count0), .wq_idle(wq_idle0),
        .dbg_state(dbg_state0)
    );

    // ---------------- clock / reset helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        st_valid = 1'b0;
        peri_ack = 1'b0;
        boot_up  = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic put(input logic [15:0] a, input logic [15:0] d);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        tick();
        st_valid = 1'b0;
    endtask

    // Records every strobed write of the GAP_CYCLES=1 instance, bounded by budget.
    task automatic collect(input int budget, input int n_want);
        got_q.delete();
        for (int i = 0; i < budget && got_q.size() < n_want; i++) begin
            if (peri_web == 1'b0) got_q.push_back({peri_addr, peri_datao});
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        total++; if (peri_web !== 1'b1) begin bad++; $display("FAIL reset_web: got %b want 1", peri_web); end
        total++; if (peri_addr !== 16'h0) begin bad++; $display("FAIL reset_addr: got %h want 0000", peri_addr); end
        total++; if (peri_datao !== 16'h0) begin bad++; $display("FAIL reset_data: got %h want 0000", peri_datao); end
        total++; if (wq_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", wq_count); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", st_ready); end
        total++; if (wq_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", wq_idle); end
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        total++; if (peri_web0 !== 1'b1) begin bad++; $display("FAIL reset_web0: got %b want 1", peri_web0); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        do_reset();
        peri_ack = 1'b1;
        put(16'h0010, 16'h1234);
        total++; if (peri_web !== 1'b1 || wq_count !== 3'd1) begin bad++;
            $display("FAIL single_E: got web=%b count=%0d want web=1 count=1", peri_web, wq_count); end
        tick();
        total++; if (peri_web !== 1'b0 || peri_addr !== 16'h0010 || peri_datao !== 16'h1234) begin bad++;
            $display("FAIL single_E1: got web=%b %h/%h want web=0 0010/1234", peri_web, peri_addr, peri_datao); end
        tick();
        total++; if (peri_web !== 1'b1 || dbg_state !== 2'd2) begin bad++;
            $display("FAIL single_E2: got web=%b state=%0d want web=1 state=2", peri_web, dbg_state); end
        tick();
        total++; if (wq_idle !== 1'b1 || peri_web !== 1'b1) begin bad++;
            $display("FAIL single_E3: got idle=%b web=%b want idle=1 web=1", wq_idle, peri_web); end
    endtask

    task automatic test_full();
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            put(16'h0100 + 16'(i), 16'h00A0 + 16'(i));
            exp_q.push_back({16'h0100 + 16'(i), 16'h00A0 + 16'(i)});
        end
        total++; if (wq_count !== 3'd4 || st_ready !== 1'b0) begin bad++;
            $display("FAIL full_count: got count=%0d ready=%b want count=4 ready=0", wq_count, st_ready); end
        total++; if (peri_web !== 1'b0 || peri_addr !== 16'h0100) begin bad++;
            $display("FAIL full_inflight: got web=%b addr=%h want web=0 addr=0100", peri_web, peri_addr); end
        // matching tail address while full must still be refused
        put(16'h0104, 16'hFFFF);
        total++; if (wq_count !== 3'd4) begin bad++; $display("FAIL full_refuse: got count=%0d want 4", wq_count); end
        peri_ack = 1'b1;
        collect(40, 5);
        total++; if (got_q.size() !== exp_q.size()) begin bad++;
            $display("FAIL full_drain_n: got %0d writes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL full_drain_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        tick();
        total++; if (wq_idle !== 1'b1) begin bad++; $display("FAIL full_idle: got %b want 1", wq_idle); end
    endtask

    task automatic test_coalesce();
        do_reset();
        put(16'h0020, 16'h000A);
        put(16'h0030, 16'h000B);
        put(16'h0030, 16'h000C);
        total++; if (wq_count !== 3'd1 || peri_addr !== 16'h0020 || peri_web !== 1'b0) begin bad++;
            $display("FAIL coal_count: got count=%0d addr=%h web=%b want 1 0020 0", wq_count, peri_addr, peri_web); end
        exp_q.delete();
        exp_q.push_back({16'h0020, 16'h000A});
        exp_q.push_back({16'h0030, 16'h000C});
        peri_ack = 1'b1;
        collect(12, 3);
        total++; if (got_q.size() !== exp_q.size()) begin bad++;
            $display("FAIL coal_n: got %0d writes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL coal_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        // tail leaving on the same edge: the second store must be pushed
        do_reset();
        put(16'h0040, 16'h000D);
        put(16'h0040, 16'h000E);
        total++; if (wq_count !== 3'd1) begin bad++; $display("FAIL coal_tailpop: got count=%0d want 1", wq_count); end
        exp_q.delete();
        exp_q.push_back({16'h0040, 16'h000D});
        exp_q.push_back({16'h0040, 16'h000E});
        peri_ack = 1'b1;
        collect(12, 3);
        total++; if (got_q.size() !== exp_q.size()) begin bad++;
            $display("FAIL tailpop_n: got %0d writes want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++;
                $display("FAIL tailpop_%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) put(16'h0200 + 16'(i), 16'h00B0 + 16'(i));
        total++; if (wq_count0 !== 3'd3 || peri_web0 !== 1'b0) begin bad++;
            $display("FAIL b2b_pre: got count=%0d web=%b want 3 0", wq_count0, peri_web0); end
        peri_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (peri_web0 !== 1'b0 || peri_addr0 !== 16'h0200 + 16'(i) || peri_datao0 !== 16'h00B0 + 16'(i)) begin bad++;
                $display("FAIL b2b_%0d: got web=%b %h/%h want web=0 %h/%h", i, peri_web0, peri_addr0, peri_datao0,
                         16'h0200 + 16'(i), 16'h00B0 + 16'(i)); end
            tick();
        end
        total++; if (peri_web0 !== 1'b1 || wq_idle0 !== 1'b1) begin bad++;
            $display("FAIL b2b_end: got web=%b idle=%b want 1 1", peri_web0, wq_idle0); end
    endtask

    task automatic test_reset_mid_write();
        int strobes;
        do_reset();
        for (int i = 0; i < 3; i++) put(16'h0400 + 16'(i), 16'h0055);
        total++; if (wq_count !== 3'd2 || dbg_state !== 2'd1 || peri_web !== 1'b0) begin bad++;
            $display("FAIL mid_pre: got count=%0d state=%0d web=%b want 2 1 0", wq_count, dbg_state, peri_web); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total++; if (peri_web !== 1'b1 || wq_count !== 3'd0 || st_ready !== 1'b1) begin bad++;
            $display("FAIL mid_rst: got web=%b count=%0d ready=%b want 1 0 1", peri_web, wq_count, st_ready); end
        peri_ack = 1'b1;
        strobes = 0;
        for (int i = 0; i < 10; i++) begin
            if (peri_web == 1'b0 || peri_web0 == 1'b0) strobes++;
            tick();
        end
        total++; if (strobes !== 0) begin bad++; $display("FAIL mid_nowrite: got %0d strobes want 0", strobes); end
    endtask

    task automatic test_boot();
        do_reset();
        st_valid = 1'b1;
        st_addr  = 16'h0300;
        st_data  = 16'h00C3;
        boot_up  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (wq_count !== 3'd0 || peri_web !== 1'b1) begin bad++;
                $display("FAIL boot_%0d: got count=%0d web=%b want 0 1", i, wq_count, peri_web); end
        end
        boot_up = 1'b0;
        tick();
        st_valid = 1'b0;
        total++; if (wq_count !== 3'd1) begin bad++; $display("FAIL boot_accept: got count=%0d want 1", wq_count); end
        tick();
        total++; if (peri_web !== 1'b0 || peri_addr !== 16'h0300 || peri_datao !== 16'h00C3) begin bad++;
            $display("FAIL boot_write: got web=%b %h/%h want 0 0300/00C3", peri_web, peri_addr, peri_datao); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single_write();
        test_full();
        test_coalesce();
        test_back_to_back();
        test_reset_mid_write();
        test_boot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
